// File: rtl/beam_pkg.sv
// beam_pkg: shared definitions for the beam animation path.
//   - direction encodings for the dir input
//   - screen and block geometry, from which the default position limits come
//   - FSM state encoding used by beam_path
//   - at_edge(): true when a block cannot take one more step in a direction
package beam_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int BLOCK_W  = 2;
    localparam int BLOCK_H  = 4;

    // Largest top-left coordinate that keeps the whole block on screen.
    localparam int X_MAX_DEF = SCREEN_W - BLOCK_W;
    localparam int Y_MAX_DEF = SCREEN_H - BLOCK_H;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW_GO,
        ST_DRAW_WAIT,
        ST_DELAY,
        ST_ERASE_GO,
        ST_ERASE_WAIT,
        ST_STEP,
        ST_DONE
    } state_t;

    function automatic logic at_edge(input logic [1:0] d,
                                     input logic [7:0] x,
                                     input logic [6:0] y,
                                     input logic [7:0] x_lim,
                                     input logic [6:0] y_lim);
        logic r;
        case (d)
            DIR_RIGHT: r = (x == x_lim);
            DIR_LEFT:  r = (x == 8'd0);
            DIR_DOWN:  r = (y == y_lim);
            default:   r = (y == 7'd0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/beam_path_frame_delay.sv
// frame_delay: loadable down-counter that times the pause between a draw
// and its erase.
//   clk, rst : clock, asynchronous active-high reset
//   load     : preload DELAY_CYCLES-1
//   enable   : count down by one per cycle, saturating at zero
//   zero     : counter is zero
// Loading DELAY_CYCLES-1 and leaving on the zero cycle gives a wait of
// exactly DELAY_CYCLES cycles.
module frame_delay #(
    parameter int DELAY_CYCLES = 833_333
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic zero
);

    localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/beam_path.sv
// beam_path: sequencer that animates a 2x4 block in a straight line by
// driving beam_coord: draw, wait a frame, erase, step one pixel, repeat.
// Stops after `steps` moves or when the next move would leave the screen.
//   CLOCK_50, reset        : clock, asynchronous active-high reset
//   start                  : begin a path (only looked at in IDLE)
//   x_start, y_start       : initial block position (clipped to limits)
//   dir, steps, colour     : direction, number of moves, beam colour
//   bc_done                : completion pulse from beam_coord
//   bc_go, bc_x, bc_y,
//   bc_colour              : request to beam_coord
//   busy                   : not in IDLE
//   finished               : one-cycle pulse at the end of a path
//   hit_edge               : path stopped at a screen boundary
module beam_path
    import beam_pkg::*;
#(
    parameter int DELAY_CYCLES = 833_333,
    parameter int X_MAX        = X_MAX_DEF,
    parameter int Y_MAX        = Y_MAX_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_start,
    input  logic [6:0] y_start,
    input  logic [1:0] dir,
    input  logic [7:0] steps,
    input  logic [2:0] colour,
    input  logic       bc_done,
    output logic       bc_go,
    output logic [7:0] bc_x,
    output logic [6:0] bc_y,
    output logic [2:0] bc_colour,
    output logic       busy,
    output logic       finished,
    output logic       hit_edge
);

    localparam logic [7:0] X_LIM = 8'(X_MAX);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX);

    state_t     state_q, state_d;
    logic [7:0] cur_x_q, cur_x_d;
    logic [6:0] cur_y_q, cur_y_d;
    logic [1:0] dir_r_q, dir_r_d;
    logic [2:0] col_r_q, col_r_d;
    logic [7:0] remaining_q, remaining_d;
    logic       bc_go_q, bc_go_d;
    logic [2:0] bc_colour_q, bc_colour_d;
    logic       busy_q, busy_d;
    logic       finished_q, finished_d;
    logic       hit_edge_q, hit_edge_d;

    logic dly_load, dly_en, dly_zero;

    frame_delay #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_frame_delay (
        .clk   (CLOCK_50),
        .rst   (reset),
        .load  (dly_load),
        .enable(dly_en),
        .zero  (dly_zero)
    );

    // Outputs are registered: each *_d is the value for the state being
    // entered, so bc_go/finished line up with DRAW_GO/ERASE_GO/DONE.
    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        dir_r_d     = dir_r_q;
        col_r_d     = col_r_q;
        remaining_d = remaining_q;
        bc_go_d     = 1'b0;
        bc_colour_d = bc_colour_q;
        finished_d  = 1'b0;
        hit_edge_d  = hit_edge_q;
        dly_load    = 1'b0;
        dly_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_x_d     = (x_start > X_LIM) ? X_LIM : x_start;
                    cur_y_d     = (y_start > Y_LIM) ? Y_LIM : y_start;
                    dir_r_d     = dir;
                    col_r_d     = colour;
                    remaining_d = steps;
                    hit_edge_d  = 1'b0;
                    bc_go_d     = 1'b1;
                    bc_colour_d = colour;
                    state_d     = ST_DRAW_GO;
                end
            end
            ST_DRAW_GO: state_d = ST_DRAW_WAIT;
            ST_DRAW_WAIT: begin
                if (bc_done) begin
                    if (remaining_q == 8'd0) begin
                        finished_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (at_edge(dir_r_q, cur_x_q, cur_y_q, X_LIM, Y_LIM)) begin
                        hit_edge_d = 1'b1;
                        finished_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        dly_load = 1'b1;
                        state_d  = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                dly_en = 1'b1;
                if (dly_zero) begin
                    bc_go_d     = 1'b1;
                    bc_colour_d = 3'b000;
                    state_d     = ST_ERASE_GO;
                end
            end
            ST_ERASE_GO: state_d = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (bc_done) state_d = ST_STEP;
            end
            ST_STEP: begin
                // The edge check in DRAW_WAIT guarantees this move is in range.
                case (dir_r_q)
                    DIR_RIGHT: cur_x_d = cur_x_q + 8'd1;
                    DIR_LEFT:  cur_x_d = cur_x_q - 8'd1;
                    DIR_DOWN:  cur_y_d = cur_y_q + 7'd1;
                    default:   cur_y_d = cur_y_q - 7'd1;
                endcase
                remaining_d = remaining_q - 8'd1;
                bc_go_d     = 1'b1;
                bc_colour_d = col_r_q;
                state_d     = ST_DRAW_GO;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            dir_r_q     <= '0;
            col_r_q     <= '0;
            remaining_q <= '0;
            bc_go_q     <= 1'b0;
            bc_colour_q <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            hit_edge_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            dir_r_q     <= dir_r_d;
            col_r_q     <= col_r_d;
            remaining_q <= remaining_d;
            bc_go_q     <= bc_go_d;
            bc_colour_q <= bc_colour_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            hit_edge_q  <= hit_edge_d;
        end
    end

    assign bc_go     = bc_go_q;
    assign bc_x      = cur_x_q;
    assign bc_y      = cur_y_q;
    assign bc_colour = bc_colour_q;
    assign busy      = busy_q;
    assign finished  = finished_q;
    assign hit_edge  = hit_edge_q;

endmodule

// File: tb/tb_beam_path.sv
// tb_beam_path: directed and randomized paths against a reference model
// that lists every expected beam_coord request (cycle, position, colour),
// the finish cycle, busy length and hit_edge for a path.
module tb_beam_path;

    localparam int D    = 4;
    localparam int XM   = 158;
    localparam int YM   = 116;
    localparam int LAT  = 11;   // go cycle -> done cycle of the beam_coord model

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_start;
    logic [6:0] y_start;
    logic [1:0] dir;
    logic [7:0] steps;
    logic [2:0] colour;
    logic       bc_done;
    logic       bc_go;
    logic [7:0] bc_x;
    logic [6:0] bc_y;
    logic [2:0] bc_colour;
    logic       busy;
    logic       finished;
    logic       hit_edge;

    logic model_done = 1'b0;
    logic spur_done  = 1'b0;
    assign bc_done = model_done | spur_done;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    beam_path #(.DELAY_CYCLES(D), .X_MAX(XM), .Y_MAX(YM)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .x_start  (x_start),
        .y_start  (y_start),
        .dir      (dir),
        .steps    (steps),
        .colour   (colour),
        .bc_done  (bc_done),
        .bc_go    (bc_go),
        .bc_x     (bc_x),
        .bc_y     (bc_y),
        .bc_colour(bc_colour),
        .busy     (busy),
        .finished (finished),
        .hit_edge (hit_edge)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // beam_coord stand-in: done pulse LAT cycles after a go.
    int bc_cnt = 0;
    always @(negedge clk) begin
        model_done = 1'b0;
        if (reset) begin
            bc_cnt = 0;
        end else begin
            if (bc_cnt > 0) begin
                bc_cnt = bc_cnt - 1;
                if (bc_cnt == 0) model_done = 1'b1;
            end
            if (bc_go) bc_cnt = LAT;
        end
    end

    // Observed requests and finish pulses.
    int o_cyc[$], o_x[$], o_y[$], o_col[$], o_fin[$];
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (bc_go) begin
            o_cyc.push_back(cyc); o_x.push_back(int'(bc_x));
            o_y.push_back(int'(bc_y)); o_col.push_back(int'(bc_colour));
        end
        if (finished) o_fin.push_back(cyc);
        if (busy) busy_cnt++;
    end

    // Expected behaviour of one path.
    int e_cyc[$], e_x[$], e_y[$], e_col[$];
    int e_fin, e_busy;
    int e_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        o_cyc.delete(); o_x.delete(); o_y.delete(); o_col.delete(); o_fin.delete();
        busy_cnt = 0;
    endtask

    // s = cycle whose closing edge samples start.
    task automatic build_exp(input int s, input int x0, input int y0, input int d,
                             input int n, input int c);
        int x, y, g, dn, eg, rem;
        e_cyc.delete(); e_x.delete(); e_y.delete(); e_col.delete();
        x = (x0 > XM) ? XM : x0;
        y = (y0 > YM) ? YM : y0;
        rem = n; g = s + 1; e_hit = 0;
        forever begin
            e_cyc.push_back(g); e_x.push_back(x); e_y.push_back(y); e_col.push_back(c);
            dn = g + LAT;
            if (rem == 0) break;
            if ((d == 0 && x == XM) || (d == 1 && x == 0) ||
                (d == 2 && y == YM) || (d == 3 && y == 0)) begin
                e_hit = 1;
                break;
            end
            eg = dn + 1 + D;
            e_cyc.push_back(eg); e_x.push_back(x); e_y.push_back(y); e_col.push_back(0);
            g = eg + LAT + 2;
            case (d)
                0: x++;
                1: x--;
                2: y++;
                default: y--;
            endcase
            rem--;
        end
        e_fin  = dn + 1;
        e_busy = e_fin - s;
    endtask

    task automatic compare_path(input string name);
        int m;
        chk({name, "_ngo"}, o_cyc.size(), e_cyc.size());
        m = (o_cyc.size() < e_cyc.size()) ? o_cyc.size() : e_cyc.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_go%0d_cyc", name, i), o_cyc[i], e_cyc[i]);
            chk($sformatf("%s_go%0d_x", name, i), o_x[i], e_x[i]);
            chk($sformatf("%s_go%0d_y", name, i), o_y[i], e_y[i]);
            chk($sformatf("%s_go%0d_col", name, i), o_col[i], e_col[i]);
        end
        chk({name, "_nfin"}, o_fin.size(), 1);
        if (o_fin.size() > 0) chk({name, "_fin_cyc"}, o_fin[0], e_fin);
        chk({name, "_busy_len"}, busy_cnt, e_busy);
        chk({name, "_hit_edge"}, hit_edge, e_hit);
    endtask

    task automatic run_path(input string name, input int x, input int y, input int d,
                            input int n, input int c, input bit inject);
        int s, budget;
        clear_obs();
        @(negedge clk);
        x_start = 8'(x); y_start = 7'(y); dir = 2'(d); steps = 8'(n); colour = 3'(c);
        start = 1'b1;
        s = cyc;
        build_exp(s, x, y, d, n, c);
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (o_fin.size() == 0 && budget < 3000) begin
            if (inject && budget == 3) begin
                // A start during DRAW_WAIT with different parameters.
                x_start = 8'(x + 7); y_start = 7'(y + 3); dir = ~2'(d);
                steps = 8'd200; colour = ~3'(c); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        chk({name, "_within_budget"}, (budget < 3000), 1'b1);
        repeat (3) @(negedge clk);
        compare_path(name);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x_start = '0; y_start = '0;
        dir = '0; steps = '0; colour = '0;
        repeat (2) @(negedge clk);
        chk("rst_bc_go", bc_go, 0);
        chk("rst_bc_x", bc_x, 0);
        chk("rst_bc_y", bc_y, 0);
        chk("rst_bc_colour", bc_colour, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_hit_edge", hit_edge, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_path("basic", 10, 20, 0, 3, 5, 0);
        run_path("edge_right", 157, 5, 0, 10, 6, 0);
        run_path("up_origin", 0, 0, 3, 5, 2, 0);
        run_path("clip_corner", 200, 127, 2, 4, 1, 0);
        run_path("zero_steps", 30, 40, 2, 0, 7, 0);

        // Spurious done while idle: no request, stays idle, hit_edge kept.
        clear_obs();
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("spur_ngo", o_cyc.size(), 0);
        chk("spur_busy", busy_cnt, 0);
        chk("spur_hit_edge", hit_edge, 0);

        // Reset asynchronously while in DELAY of a path.
        clear_obs();
        @(negedge clk);
        x_start = 8'd10; y_start = 7'd20; dir = 2'd0; steps = 8'd3; colour = 3'd5;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_bc_go", bc_go, 0);
        chk("mid_rst_bc_x", bc_x, 0);
        chk("mid_rst_bc_y", bc_y, 0);
        chk("mid_rst_bc_colour", bc_colour, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_finished", finished, 0);
        chk("mid_rst_hit_edge", hit_edge, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_path("after_rst", 80, 60, 1, 2, 3, 0);

        run_path("start_busy", 50, 60, 2, 2, 3, 1);

        for (int i = 0; i < 8; i++) begin
            int rx, ry, rd;
            rd = int'($urandom_range(0, 3));
            // Start near the edge in the chosen direction half of the time.
            if ($urandom_range(0, 1) == 1) begin
                rx = (rd == 0) ? int'($urandom_range(154, 175)) :
                     (rd == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 175));
                ry = (rd == 2) ? int'($urandom_range(112, 127)) :
                     (rd == 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
            end else begin
                rx = int'($urandom_range(0, 175));
                ry = int'($urandom_range(0, 127));
            end
            run_path($sformatf("rnd%0d", i), rx, ry, rd,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
